// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM state encoding
// and the register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_FLUSH_PEND = 2'd2,
        ST_ERR        = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the
// source operands of the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 mem_read_ex,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    output logic                 load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign rs1_hit_s = rs1_used_id & (rs1_id == rd_ex);
    assign rs2_hit_s = rs2_used_id & (rs2_id == rd_ex);
    assign load_use  = mem_read_ex & (rd_ex != {REG_IDX_W{1'b0}}) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller with memory-wait timeout.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read_ex,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic                 branch_taken_ex,
    input  logic                 dmem_req_mem,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_bubble,
    output logic                 mem_timeout_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    logic        pend_q, pend_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        load_use_s;
    logic        mem_stall_s;
    logic        mem_done_s;

    hazard_detect u_hazard (
        .mem_read_ex (mem_read_ex),
        .rd_ex       (rd_ex),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .load_use    (load_use_s)
    );

    // A ready pulse without an outstanding request is meaningless and ignored.
    assign mem_stall_s     = dmem_req_mem & ~dmem_ready;
    assign mem_done_s      = dmem_req_mem & dmem_ready;
    assign mem_timeout_err = err_q;

    // Stage enables and bubble/flush controls; zero-latency from inputs.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            {if_id_flush, id_ex_flush, mem_wb_bubble}         = 3'b111;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                        mem_wb_bubble = 1'b1;
                    end else if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_done_s) begin
                        pc_write = 1'b1;
                    end else begin
                        {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                        mem_wb_bubble = 1'b1;
                    end
                end
                ST_FLUSH_PEND: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ST_ERR: begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                    mem_wb_bubble = 1'b1;
                end
                default: begin
                    {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
                    mem_wb_bubble = 1'b1;
                end
            endcase
        end
    end

    // Next-state, wait counter and deferred-flush bookkeeping.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd1;
                    pend_d  = branch_taken_ex;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                pend_d = pend_q | branch_taken_ex;
                if (mem_done_s) begin
                    wait_d  = 8'd0;
                    state_d = (pend_q | branch_taken_ex) ? ST_FLUSH_PEND : ST_RUN;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if ((wait_q + 8'd1) == TIMEOUT_C) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
            end
            ST_FLUSH_PEND: begin
                pend_d  = 1'b0;
                state_d = ST_RUN;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
        err_d = err_q | (state_d == ST_ERR);
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             any_we_low_s;

    assign any_we_low_s = ~(pc_write & if_id_write & id_ex_write & ex_mem_write);
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            if (any_we_low_s && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (if_id_flush && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, multi-cycle
// corner-case sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    localparam logic [7:0] CTL_RST = 8'b0000_1110;
    localparam logic [7:0] CTL_RUN = 8'b1111_0000;
    localparam logic [7:0] CTL_FRZ = 8'b0000_0010;
    localparam logic [7:0] CTL_BR  = 8'b1111_1100;
    localparam logic [7:0] CTL_LU  = 8'b0011_0100;
    localparam logic [7:0] CTL_ERR = 8'b0000_0011;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read_ex, rs1_used_id, rs2_used_id, branch_taken_ex, dmem_req_mem, dmem_ready;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: length of current memory stall (0 = none), flush owed
    // after release, flush being issued this cycle, sticky error, counters.
    int m_stall_len = 0;
    bit m_owed = 1'b0;
    bit m_flush_now = 1'b0;
    bit m_err = 1'b0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    logic [7:0] last_ctl;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive just after posedge, compare at negedge, advance model at posedge.
    task automatic step(input logic rn, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic br, input logic rq, input logic rdy,
                        input string tag);
        logic [7:0] exp;
        bit lu;
        rst_n = rn; mem_read_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
        rs1_used_id = u1; rs2_used_id = u2; branch_taken_ex = br;
        dmem_req_mem = rq; dmem_ready = rdy;
        if (!rn) begin
            m_stall_len = 0; m_owed = 0; m_flush_now = 0; m_err = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end
        @(negedge clk);
        lu = mr && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        if (!rn)                      exp = CTL_RST;
        else if (m_err)               exp = CTL_ERR;
        else if (m_flush_now)         exp = CTL_BR;
        else if (m_stall_len > 0)     exp = (rq && rdy) ? CTL_RUN : CTL_FRZ;
        else if (rq && !rdy)          exp = CTL_FRZ;
        else if (br)                  exp = CTL_BR;
        else if (lu)                  exp = CTL_LU;
        else                          exp = CTL_RUN;
        last_ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout_err};
        check({tag, "_ctl"}, 64'(last_ctl), 64'(exp));
        check({tag, "_stallcnt"}, 64'(stall_cycles), PERF ? 64'(m_stall_cnt) : 64'd0);
        check({tag, "_flushcnt"}, 64'(flush_count), PERF ? 64'(m_flush_cnt) : 64'd0);
        @(posedge clk);
        if (rn) begin
            if (exp[7:4] != 4'hF && m_stall_cnt < CMAX) m_stall_cnt++;
            if (exp[3] && m_flush_cnt < CMAX) m_flush_cnt++;
            if (m_err) begin
                m_err = 1'b1;
            end else if (m_flush_now) begin
                m_flush_now = 1'b0;
                m_owed = 1'b0;
            end else if (m_stall_len > 0) begin
                m_owed = m_owed | br;
                if (rq && rdy) begin
                    m_stall_len = 0;
                    m_flush_now = m_owed;
                    m_owed = 1'b0;
                end else begin
                    m_stall_len++;
                    if (m_stall_len >= TO) m_err = 1'b1;
                end
            end else if (rq && !rdy) begin
                m_stall_len = 1;
                m_owed = br;
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic mem(input logic br, input logic rq, input logic rdy, input string tag);
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, br, rq, rdy, tag);
    endtask

    task automatic rst(input string tag);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       rq;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_LU};
        tbl[1]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN};
        tbl[2]  = '{1'b1, 5'd7,  5'd1,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN};
        tbl[3]  = '{1'b1, 5'd7,  5'd1,  5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CTL_LU};
        tbl[4]  = '{1'b0, 5'd5,  5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN};
        tbl[5]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CTL_BR};
        tbl[6]  = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CTL_BR};
        tbl[7]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CTL_RUN};
        tbl[8]  = '{1'b1, 5'd3,  5'd0,  5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CTL_LU};
        tbl[9]  = '{1'b1, 5'd31, 5'd30, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN};
        tbl[10] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_LU};

        rst_n = 1'b0; mem_read_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; branch_taken_ex = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;

        rst("reset");
        check("reset_state", 64'(last_ctl), 64'(CTL_RST));
        idle("post_reset");
        check("post_reset_run", 64'(last_ctl), 64'(CTL_RUN));

        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].mr, tbl[i].rd, tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2,
                 tbl[i].br, tbl[i].rq, tbl[i].rdy, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), 64'(last_ctl), 64'(tbl[i].exp));
        end

        // Memory wait: three frozen cycles then release.
        rst("w_rst");
        for (int i = 0; i < 3; i++) begin
            mem(1'b0, 1'b1, 1'b0, "w_stall");
            check($sformatf("wait_frozen%0d", i), 64'(last_ctl), 64'(CTL_FRZ));
        end
        mem(1'b0, 1'b1, 1'b1, "w_rel");
        check("wait_release", 64'(last_ctl), 64'(CTL_RUN));
        idle("w_after");
        check("wait_stallcnt", 64'(stall_cycles), PERF ? 64'd3 : 64'd0);
        check("wait_flushcnt", 64'(flush_count), 64'd0);

        // Branch taken on second stall cycle: flush deferred to one post-release cycle.
        rst("b_rst");
        mem(1'b0, 1'b1, 1'b0, "b_s1");
        mem(1'b1, 1'b1, 1'b0, "b_s2");
        check("br_wait_noflush", 64'(last_ctl), 64'(CTL_FRZ));
        mem(1'b0, 1'b1, 1'b0, "b_s3");
        mem(1'b0, 1'b1, 1'b1, "b_rel");
        check("br_release_noflush", 64'(last_ctl), 64'(CTL_RUN));
        idle("b_fl");
        check("br_deferred_flush", 64'(last_ctl), 64'(CTL_BR));
        idle("b_after");
        check("br_flush_once", 64'(last_ctl), 64'(CTL_RUN));

        // Timeout: four low cycles lead to a sticky error.
        rst("t_rst");
        for (int i = 0; i < TO; i++) mem(1'b0, 1'b1, 1'b0, "t_stall");
        mem(1'b0, 1'b1, 1'b1, "t_err");
        check("timeout_err", 64'(last_ctl), 64'(CTL_ERR));
        for (int i = 0; i < 260; i++) mem(1'b1, 1'b1, 1'b1, "t_hold");
        check("timeout_sticky", 64'(last_ctl), 64'(CTL_ERR));
        check("stall_saturate", 64'(stall_cycles), PERF ? 64'd255 : 64'd0);
        rst("t_clr");
        check("err_cleared", 64'(mem_timeout_err), 64'd0);
        idle("t_run");
        check("err_recover", 64'(last_ctl), 64'(CTL_RUN));

        // Reset in the middle of a wait with a pending flush.
        rst("r_rst");
        mem(1'b0, 1'b1, 1'b0, "r_s1");
        mem(1'b1, 1'b1, 1'b0, "r_s2");
        rst("r_mid");
        check("rst_mid_ctl", 64'(last_ctl), 64'(CTL_RST));
        check("rst_mid_cnt", 64'(stall_cycles), 64'd0);
        idle("r_run1");
        check("rst_mid_run", 64'(last_ctl), 64'(CTL_RUN));
        idle("r_run2");
        check("rst_mid_nopend", 64'(last_ctl), 64'(CTL_RUN));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) < 13), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, maximum consecutive dmem_ready-low cycles tolerated in MEM_WAIT (range 2..255).
REQ-002 Parameter: CNT_W, default 32, width of performance counters.
REQ-003 Reset and clocking: single clock clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 mem_read_ex  in  1  instruction in EX is a load.
REQ-007 rd_ex  in  5  destination register of the EX instruction.
REQ-008 rs1_id, rs2_id  in  5 each  source registers of the ID instruction.
REQ-009 rs1_used_id, rs2_used_id  in  1 each  ID instruction reads rs1 / rs2.
REQ-010 branch_taken_ex  in  1  EX resolved a taken branch or jump.
REQ-011 dmem_req_mem  in  1  MEM stage issues a data-memory access this cycle.
REQ-012 dmem_ready  in  1  data memory completes the access this cycle.
REQ-013 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage-register load enables.
REQ-014 if_id_flush, id_ex_flush  out  1 each  load a bubble (control fields zeroed) into that register.
REQ-015 mem_wb_bubble  out  1  force reg_write and mem_to_reg of MEM/WB input to 0.
REQ-016 mem_timeout_err  out  1  sticky error flag.
REQ-017 stall_cycles, flush_count  out  CNT_W each  performance counters.

Function
REQ-018 FSM states RUN, MEM_WAIT, FLUSH_PEND, ERR; reset state RUN.
REQ-019 RUN, dmem_req_mem=1 and dmem_ready=0: all four write enables 0, mem_wb_bubble=1, next state MEM_WAIT, wait counter loaded with 1.
REQ-020 MEM_WAIT, dmem_ready=0: same freeze outputs; wait counter increments; when counter equals MEM_TIMEOUT, next state ERR.
REQ-021 MEM_WAIT, dmem_ready=1: all write enables 1, mem_wb_bubble=0, no flush; next state FLUSH_PEND if a flush is pending, else RUN.
REQ-022 branch_taken_ex=1 in RUN with no memory stall: if_id_flush=1, id_ex_flush=1, write enables 1, same cycle (zero latency).
REQ-023 branch_taken_ex=1 sampled while stalled (RUN entering MEM_WAIT, or MEM_WAIT): pending-flush bit set; branch_taken_ex ignored further until cleared.
REQ-024 FLUSH_PEND: if_id_flush=1, id_ex_flush=1, write enables 1 for exactly one cycle; pending bit cleared; next state RUN.
REQ-025 Load-use hazard = mem_read_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
REQ-026 Load-use in RUN, no memory stall, no branch: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1.
REQ-027 Priority: memory stall > taken branch > load-use; branch and load-use together yield REQ-022 only.
REQ-028 ERR: all write enables 0, mem_wb_bubble=1, mem_timeout_err=1; exit only by reset.
REQ-029 dmem_ready=1 without dmem_req_mem is ignored in every state.

Reset
REQ-030 While rst_n=0: state RUN, pending bit 0, wait counter 0, mem_timeout_err 0, counters 0.
REQ-031 While rst_n=0: write enables 0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
REQ-032 Reset asserted mid-MEM_WAIT or in ERR discards the stall and the pending flush; first post-reset cycle is RUN.

Configuration
REQ-033 Macro PIPE_CTRL_PERF_EN defined: stall_cycles increments each cycle any write enable is 0 outside reset; flush_count increments each cycle if_id_flush=1 outside reset; both saturate at all-ones.
REQ-034 Macro PIPE_CTRL_PERF_EN undefined: ports remain, both tied to 0, no counter flops.

Structure
REQ-035 Package pipe_ctrl_pkg holds the state enum and the register-index width constant (5).
REQ-036 Load-use comparison is sub-module hazard_detect (purely combinational); FSM and counters live in pipeline_ctrl.

Verification
REQ-037 Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; rd_ex=0 -> no stall.
REQ-038 Memory wait: dmem_req_mem=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with mem_wb_bubble=1, release on 4th cycle.
REQ-039 Branch during wait: branch_taken_ex=1 on the second stall cycle -> no flush until release, then exactly one cycle both flushes=1.
REQ-040 Timeout: MEM_TIMEOUT=4, dmem_ready held low -> ERR after 4 stall cycles, mem_timeout_err=1 sticky until rst_n low.
REQ-041 Reset mid-MEM_WAIT: rst_n low 1 cycle -> flushes 1, counters 0, then RUN with write enables 1.
REQ-042 PIPE_CTRL_PERF_EN defined, scenario REQ-038 -> stall_cycles=3, flush_count=0; undefined -> both 0.
